// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 control sequencer: opcodes, control-word
// bit positions, per-state control words and the T-state index enum.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word layout, bit 11 down to bit 0.
  localparam int B_CP   = 11;
  localparam int B_EP   = 10;
  localparam int B_N_LM = 9;
  localparam int B_N_CE = 8;
  localparam int B_N_LI = 7;
  localparam int B_N_EI = 6;
  localparam int B_N_LA = 5;
  localparam int B_EA   = 4;
  localparam int B_SU   = 3;
  localparam int B_EU   = 2;
  localparam int B_N_LB = 1;
  localparam int B_N_LO = 0;

  localparam logic [11:0] M_CP   = 12'd1 << B_CP;
  localparam logic [11:0] M_EP   = 12'd1 << B_EP;
  localparam logic [11:0] M_N_LM = 12'd1 << B_N_LM;
  localparam logic [11:0] M_N_CE = 12'd1 << B_N_CE;
  localparam logic [11:0] M_N_LI = 12'd1 << B_N_LI;
  localparam logic [11:0] M_N_EI = 12'd1 << B_N_EI;
  localparam logic [11:0] M_N_LA = 12'd1 << B_N_LA;
  localparam logic [11:0] M_EA   = 12'd1 << B_EA;
  localparam logic [11:0] M_SU   = 12'd1 << B_SU;
  localparam logic [11:0] M_EU   = 12'd1 << B_EU;
  localparam logic [11:0] M_N_LB = 12'd1 << B_N_LB;
  localparam logic [11:0] M_N_LO = 12'd1 << B_N_LO;

  // Every active-low strobe high, every active-high strobe low.
  localparam logic [11:0] CON_IDLE   = 12'h3E3;

  localparam logic [11:0] CON_T1     = (CON_IDLE | M_EP) & ~M_N_LM;
  localparam logic [11:0] CON_T2     = CON_IDLE | M_CP;
  localparam logic [11:0] CON_T3     = CON_IDLE & ~(M_N_CE | M_N_LI);
  localparam logic [11:0] CON_T4_MEM = CON_IDLE & ~(M_N_EI | M_N_LM);
  localparam logic [11:0] CON_T4_OUT = (CON_IDLE | M_EA) & ~M_N_LO;
  localparam logic [11:0] CON_T5_LDA = CON_IDLE & ~(M_N_CE | M_N_LA);
  localparam logic [11:0] CON_T5_ALU = CON_IDLE & ~(M_N_CE | M_N_LB);
  localparam logic [11:0] CON_T6_ADD = (CON_IDLE | M_EU) & ~M_N_LA;
  localparam logic [11:0] CON_T6_SUB = (CON_IDLE | M_EU | M_SU) & ~M_N_LA;

  // Bit positions of each T-state inside the one-hot ring.
  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4,
    T6 = 3'd5
  } t_state_e;

  localparam logic [5:0] T_RESET = 6'b000001;

  function automatic logic is_onehot(input logic [5:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) n += int'(v[i]);
    return n == 1;
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot ring counter. Rotates one position per enabled edge,
// freezes while hold is set, and falls back to T1 from any non-one-hot value.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       advance,
  input  logic       hold,
  output logic [5:0] state
);

  // Ring rotation with illegal-state recovery taking priority over hold.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= T_RESET;
    end else if (!is_onehot(state)) begin
      state <= T_RESET;
    end else if (advance && !hold) begin
      state <= {state[4:0], state[5]};
    end
  end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: ring counter, opcode decode into the 12-bit
// control word, halt latch and optional single-step front end.
// Optional feature macro: SAP1_STEP_EN (adds the step input; the ring then
// advances only on a synchronised rising edge of step).
module sap1_controller
  import sap1_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  opcode,
`ifdef SAP1_STEP_EN
  input  logic        step,
`endif
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        hlt
);

  logic        run;
  logic        step_pulse;
  logic        advance;
  logic        halt_now;
  logic        hold;
  logic [11:0] word;

`ifdef SAP1_STEP_EN
  logic step_meta;
  logic step_sync;
  logic step_prev;

  // Two-flop synchroniser followed by a delay flop for edge detection.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step_meta <= 1'b0;
      step_sync <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      step_meta <= step;
      step_sync <= step_meta;
      step_prev <= step_sync;
    end
  end

  assign step_pulse = step_sync & ~step_prev;
`else
  assign step_pulse = 1'b1;
`endif

  // run stays low through the first edge after clr release so T1 gets a
  // full cycle before the ring starts moving.
  assign advance  = run & step_pulse;
  assign halt_now = advance & t_state[T4] & (opcode == OP_HLT);
  assign hold     = hlt | halt_now;

  sap1_ring_counter u_ring (
    .clk     (clk),
    .clr     (clr),
    .advance (advance),
    .hold    (hold),
    .state   (t_state)
  );

  // Start-up qualifier and sticky halt flag; only clr releases a halt.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      run <= 1'b0;
      hlt <= 1'b0;
    end else begin
      run <= 1'b1;
      if (halt_now) hlt <= 1'b1;
    end
  end

  // Decode the current T-state and opcode into the raw control word.
  always_comb begin
    word = CON_IDLE;
    if (is_onehot(t_state)) begin
      if (t_state[T1]) begin
        word = CON_T1;
      end else if (t_state[T2]) begin
        word = CON_T2;
      end else if (t_state[T3]) begin
        word = CON_T3;
      end else if (t_state[T4]) begin
        if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB)
          word = CON_T4_MEM;
        else if (opcode == OP_OUT)
          word = CON_T4_OUT;
      end else if (t_state[T5]) begin
        if (opcode == OP_LDA)
          word = CON_T5_LDA;
        else if (opcode == OP_ADD || opcode == OP_SUB)
          word = CON_T5_ALU;
      end else begin
        if (opcode == OP_ADD)
          word = CON_T6_ADD;
        else if (opcode == OP_SUB)
          word = CON_T6_SUB;
      end
    end
  end

  // Strobes are suppressed in reset, before the first post-reset edge,
  // while halted, and (in step mode) outside the single step cycle.
  always_comb begin
    con = word;
    if (clr || !run || hlt || !step_pulse) con = CON_IDLE;
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: the driver pushes the expected
// {con, t_state, hlt} for each cycle it drives, and a monitor pops and
// compares at the falling edge.
module tb_sap1_controller;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        hlt;
`ifdef SAP1_STEP_EN
  logic        step = 1'b0;
`endif

  localparam logic [11:0] IDLE = 12'h3E3;

  typedef struct {
    logic [11:0] con;
    logic [5:0]  ts;
    logic        hlt;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sap1_controller dut (
    .clk     (clk),
    .clr     (clr),
    .opcode  (opcode),
`ifdef SAP1_STEP_EN
    .step    (step),
`endif
    .con     (con),
    .t_state (t_state),
    .hlt     (hlt)
  );

  // Behavioural model: which strobes fire in step t (1..6) for opcode op,
  // then pack them with the active-low ones inverted.
  function automatic logic [11:0] model_con(input int t, input logic [3:0] op);
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    logic is_lda, is_add, is_sub, is_out;
    {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = '0;
    is_lda = (op == 4'h0);
    is_add = (op == 4'h1);
    is_sub = (op == 4'h2);
    is_out = (op == 4'hE);
    case (t)
      1: begin ep = 1; lm = 1; end
      2: cp = 1;
      3: begin ce = 1; li = 1; end
      4: begin
        if (is_lda || is_add || is_sub) begin ei = 1; lm = 1; end
        if (is_out) begin ea = 1; lo = 1; end
      end
      5: begin
        if (is_lda) begin ce = 1; la = 1; end
        if (is_add || is_sub) begin ce = 1; lb = 1; end
      end
      default: begin
        if (is_add || is_sub) begin eu = 1; la = 1; end
        if (is_sub) su = 1;
      end
    endcase
    return {cp, ep, ~lm, ~ce, ~li, ~ei, ~la, ea, su, eu, ~lb, ~lo};
  endfunction

  function automatic logic [5:0] ts_of(input int t);
    return 6'b000001 << (t - 1);
  endfunction

  task automatic push(input logic [11:0] c, input logic [5:0] ts, input logic h, input string tag);
    exp_t e;
    e.con = c; e.ts = ts; e.hlt = h; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare mid-cycle whenever an expectation is waiting.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (con !== mon_e.con || t_state !== mon_e.ts || hlt !== mon_e.hlt) begin
        errors++;
        $display("FAIL %s @%0t: got con=%h t_state=%b hlt=%b, want con=%h t_state=%b hlt=%b",
                 mon_e.tag, $time, con, t_state, hlt, mon_e.con, mon_e.ts, mon_e.hlt);
      end
    end
  end

  task automatic reset_seq(input int n);
    next_cycle();
    clr = 1'b1;
    push(IDLE, 6'b000001, 1'b0, "reset");
    for (int i = 1; i < n; i++) begin
      next_cycle();
      push(IDLE, 6'b000001, 1'b0, "reset");
    end
    next_cycle();
    clr = 1'b0;
    push(IDLE, 6'b000001, 1'b0, "release");
  endtask

  // One full instruction; with lit set, T1..T6 use literal words instead of the model.
  task automatic run_instr(input logic [3:0] op, input string tag, input bit lit,
                           input logic [11:0] w4, input logic [11:0] w5, input logic [11:0] w6);
    logic [11:0] w;
    for (int t = 1; t <= 6; t++) begin
      next_cycle();
      opcode = (t >= 4) ? op : 4'($urandom_range(0, 15));
      if (lit) begin
        case (t)
          1: w = 12'h5E3;
          2: w = 12'hBE3;
          3: w = 12'h263;
          4: w = w4;
          5: w = w5;
          default: w = w6;
        endcase
      end else begin
        w = model_con(t, op);
      end
      push(w, ts_of(t), 1'b0, tag);
    end
  endtask

  task automatic run_halt(input int hold_cycles);
    for (int t = 1; t <= 4; t++) begin
      next_cycle();
      opcode = (t >= 4) ? 4'hF : 4'($urandom_range(0, 15));
      push((t == 4) ? IDLE : model_con(t, 4'hF), ts_of(t), 1'b0, "hlt_fetch");
    end
    for (int i = 0; i < hold_cycles; i++) begin
      next_cycle();
      opcode = 4'($urandom_range(0, 15));
      push(IDLE, 6'b001000, 1'b1, "halted");
    end
    reset_seq(2);
  endtask

  task automatic async_reset_in_add();
    for (int t = 1; t <= 4; t++) begin
      next_cycle();
      opcode = 4'h1;
      push(model_con(t, 4'h1), ts_of(t), 1'b0, "add_pre");
    end
    next_cycle();
    #1 clr = 1'b1;
    push(IDLE, 6'b000001, 1'b0, "async_clr_t5");
    next_cycle();
    push(IDLE, 6'b000001, 1'b0, "reset");
    next_cycle();
    clr = 1'b0;
    push(IDLE, 6'b000001, 1'b0, "release");
  endtask

  task automatic run_random(input int n);
    logic [3:0] op;
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, "random", 1'b0, IDLE, IDLE, IDLE);
    end
  endtask

`ifdef SAP1_STEP_EN
  task automatic step_test();
    int cur;
    cur = 1;
    opcode = 4'h0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      push(IDLE, ts_of(cur), 1'b0, "step_idle");
    end
    for (int s = 0; s < 8; s++) begin
      next_cycle();
      step = 1'b1;
      push(IDLE, ts_of(cur), 1'b0, "step_sync0");
      next_cycle();
      step = 1'b0;
      push(IDLE, ts_of(cur), 1'b0, "step_sync1");
      next_cycle();
      push(model_con(cur, 4'h0), ts_of(cur), 1'b0, "step_word");
      cur = (cur == 6) ? 1 : cur + 1;
      for (int g = 0; g < 1 + int'($urandom_range(0, 3)); g++) begin
        next_cycle();
        push(IDLE, ts_of(cur), 1'b0, "step_gap");
      end
    end
  endtask
`endif

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: sequence did not complete, got timeout, want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset_seq(3);
`ifdef SAP1_STEP_EN
    step_test();
`else
    run_instr(4'h0, "lda", 1'b1, 12'h1A3, 12'h2C3, 12'h3E3);
    run_instr(4'h2, "sub", 1'b1, 12'h1A3, 12'h2E1, 12'h3CF);
    run_instr(4'hE, "out", 1'b1, 12'h3F2, 12'h3E3, 12'h3E3);
    run_instr(4'h1, "add", 1'b1, 12'h1A3, 12'h2E1, 12'h3C7);
    run_instr(4'h7, "nop", 1'b1, 12'h3E3, 12'h3E3, 12'h3E3);
    run_random(40);
    run_halt(22);
    run_random(5);
    async_reset_in_add();
    run_random(10);
    run_halt(4);
    run_random(3);
`endif
    next_cycle();
    next_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
